left_shift_sequencer: RTL

//  Multi-cycle left shifter: loads an operand and shifts it left by one bit per clock
//  for a programmed count. Modes: arithmetic, with sign-overflow detect, or logical, with lost-bit detect.

---
 rtl/left_shift_sequencer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/left_shift_sequencer.sv
// left_shift_sequencer
//   Multi-cycle left shifter. An accepted start loads the operand. The block
//   then shifts it left one bit per clock, min(shamt, width) times, and pulses
//   done for one cycle.
//   mode 0 (arithmetic): overflow flags a sign change (bit[w-1] != bit[w-2]
//     before a shift).
//   mode 1 (logical): overflow flags a lost 1 (bit[w-1] set before a shift).
//   Optional feature: define SHIFT_SAT_EN to make arithmetic mode saturate at
//   the first overflow. The result becomes 0111..1 for a non-negative operand
//   and 1000..0 for a negative one.
// Ports
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   start     request, sampled only in IDLE
//   in        operand, captured on an accepted start
//   shamt     shift count, captured on an accepted start (clamped to width)
//   mode      0 = arithmetic, 1 = logical, captured on an accepted start
//   out       working/result register
//   busy      high whenever the FSM is not IDLE
//   done      one-cycle pulse while the FSM is in DONE
//   overflow  sticky error flag for the current operation
module left_shift_sequencer #(
  parameter int width   = 16,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [width-1:0]   in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               mode,
  output logic [width-1:0]   out,
  output logic               busy,
  output logic               done,
  output logic               overflow
);

  localparam int CW = $clog2(width + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [width-1:0] out_q;
  logic [CW-1:0]    cnt_q;
  logic             mode_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;

  logic [CW-1:0]    cnt_d;
  logic [width-1:0] out_d;
  logic             lost_d;

`ifdef SHIFT_SAT_EN
  logic             sign_q;
  logic             sat_q;
`endif

  always_comb begin
    // Clamped load count: anything at or above width becomes width.
    cnt_d = '0;
    if (int'(shamt) >= width) cnt_d = CW'(width);
    else                      cnt_d = CW'(shamt);

    // Error condition for the shift about to happen, judged on the pre-shift value.
    lost_d = 1'b0;
    if (mode_q) lost_d = out_q[width-1];
    else        lost_d = out_q[width-1] ^ out_q[width-2];

    out_d = {out_q[width-2:0], 1'b0};
`ifdef SHIFT_SAT_EN
    // Once saturated, the value is frozen for the rest of the operation.
    if (sat_q) begin
      out_d = out_q;
    end else if (!mode_q && lost_d) begin
      out_d = sign_q ? {1'b1, {(width-1){1'b0}}} : {1'b0, {(width-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SHIFT_SAT_EN
      sign_q  <= 1'b0;
      sat_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            out_q   <= in;
            cnt_q   <= cnt_d;
            mode_q  <= mode;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_SHIFT;
`ifdef SHIFT_SAT_EN
            sign_q  <= in[width-1];
            sat_q   <= 1'b0;
`endif
          end
        end
        S_SHIFT: begin
          if (cnt_q != '0) begin
            out_q <= out_d;
            cnt_q <= cnt_q - CW'(1);
            if (lost_d) ovf_q <= 1'b1;
`ifdef SHIFT_SAT_EN
            if (!mode_q && lost_d) sat_q <= 1'b1;
`endif
          end else begin
            // done is registered, so it goes high together with the DONE state.
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out      = out_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = ovf_q;

endmodule
